mem_arbiter: RTL and testbench

Arbitrates a single-port unified memory between the instruction-fetch port and the load/store data port of the RISC-V core. This is the step from split inst_mem/data_mem to one shared memory. It holds one outstanding transaction at a time, sequenced by an IDLE/ISSUE/WAIT/RESP state machine sized to the memory's fixed read latency. Each transaction ends with a one-cycle valid pulse to the owning requester, which stalls the datapath until then.

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port
// and the load/store port, one outstanding transaction at a time.
module mem_arbiter #(
   parameter int MEM_LAT   = 1,
   parameter int DATA_PRIO = 0,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_be,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam logic FETCH = 1'b0;
   localparam logic DATA  = 1'b1;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              st_q, st_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              en_q, en_d;
   logic              we_q, we_d;
   logic              ig_q, ig_d;
   logic              dg_q, dg_d;
   logic              iv_q, iv_d;
   logic              dv_q, dv_d;
   logic              pick;

   // Owner choice when both ports ask; fetch by default.
   always_comb begin
      pick = FETCH;
      unique case (1'b1)
         (d_req && !if_req):
            pick = DATA;
         (d_req && if_req && DATA_PRIO != 0):
            pick = DATA;
         (d_req && if_req && DATA_PRIO == 0):
            pick = ~last_q;
         default:
            pick = FETCH;
      endcase
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      st_d    = st_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      en_d    = 1'b0;
      we_d    = 1'b0;
      ig_d    = 1'b0;
      dg_d    = 1'b0;
      iv_d    = 1'b0;
      dv_d    = 1'b0;
      unique case (state_q)
         IDLE, RESP: begin
            if (if_req || d_req) begin
               owner_d = pick;
               st_d    = pick & d_we;
               addr_d  = pick ? d_addr : if_addr;
               wdata_d = pick ? d_wdata : '0;
               be_d    = (pick & d_we) ? d_be : 4'hF;
               we_d    = pick & d_we;
               en_d    = 1'b1;
               ig_d    = ~pick;
               dg_d    = pick;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            cnt_d   = 4'(MEM_LAT - 1);
            last_d  = owner_q;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               if (!st_q)
                  rdata_d = mem_rdata;
               iv_d    = ~owner_q;
               dv_d    = owner_q;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default:
            state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Transaction latches and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q   <= 4'd0;
         owner_q <= FETCH;
         last_q  <= FETCH;
         st_q    <= 1'b0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= 4'h0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         ig_q    <= 1'b0;
         dg_q    <= 1'b0;
         iv_q    <= 1'b0;
         dv_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         st_q    <= st_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         en_q    <= en_d;
         we_q    <= we_d;
         ig_q    <= ig_d;
         dg_q    <= dg_d;
         iv_q    <= iv_d;
         dv_q    <= dv_d;
      end
   end

   assign if_gnt    = ig_q;
   assign d_gnt     = dg_q;
   assign if_valid  = iv_q;
   assign d_valid   = dv_q;
   assign if_rdata  = rdata_q;
   assign d_rdata   = rdata_q;
   assign mem_en    = en_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter on three
// parameter sets (LAT1/RR, LAT3/data-prio, LAT4/RR).
module tb_mem_arbiter;

   logic        clk;
   logic        rst       [3];
   logic        if_req    [3];
   logic [31:0] if_addr   [3];
   logic        if_gnt    [3];
   logic        if_valid  [3];
   logic [31:0] if_rdata  [3];
   logic        d_req     [3];
   logic        d_we      [3];
   logic [31:0] d_addr    [3];
   logic [31:0] d_wdata   [3];
   logic [3:0]  d_be      [3];
   logic        d_gnt     [3];
   logic        d_valid   [3];
   logic [31:0] d_rdata   [3];
   logic        mem_en    [3];
   logic        mem_we    [3];
   logic [31:0] mem_addr  [3];
   logic [31:0] mem_wdata [3];
   logic [3:0]  mem_be    [3];
   logic [31:0] mem_rdata [3];

   int checks = 0;
   int fails  = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_arbiter #(
         .MEM_LAT  (g == 0 ? 1 : (g == 1 ? 3 : 4)),
         .DATA_PRIO(g == 1 ? 1 : 0),
         .ADDR_W   (32)
      ) u_dut (
         .clk      (clk),
         .rst      (rst[g]),
         .if_req   (if_req[g]),
         .if_addr  (if_addr[g]),
         .if_gnt   (if_gnt[g]),
         .if_valid (if_valid[g]),
         .if_rdata (if_rdata[g]),
         .d_req    (d_req[g]),
         .d_we     (d_we[g]),
         .d_addr   (d_addr[g]),
         .d_wdata  (d_wdata[g]),
         .d_be     (d_be[g]),
         .d_gnt    (d_gnt[g]),
         .d_valid  (d_valid[g]),
         .d_rdata  (d_rdata[g]),
         .mem_en   (mem_en[g]),
         .mem_we   (mem_we[g]),
         .mem_addr (mem_addr[g]),
         .mem_wdata(mem_wdata[g]),
         .mem_be   (mem_be[g]),
         .mem_rdata(mem_rdata[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse(input int i);
      rst[i] = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int n;
      int ni;
      int nd;
      int bad;
      logic exp_d;
      logic [31:0] a;
      for (int i = 0; i < 3; i++) begin
         rst[i]       = 1'b0;
         if_req[i]    = 1'b0;
         if_addr[i]   = '0;
         d_req[i]     = 1'b0;
         d_we[i]      = 1'b0;
         d_addr[i]    = '0;
         d_wdata[i]   = '0;
         d_be[i]      = 4'h0;
         mem_rdata[i] = 32'h1111_1111;
      end
      tick();
      tick();
      for (int i = 0; i < 3; i++)
         rst[i] = 1'b1;

      // single fetch, LAT=1
      rst_pulse(0);
      rst[0] = 1'b1;
      chk("rst_en", 32'(mem_en[0]), 0);
      chk("rst_gnt", 32'(if_gnt[0] | d_gnt[0]), 0);
      chk("rst_valid", 32'(if_valid[0] | d_valid[0]), 0);
      chk("rst_rdata", if_rdata[0], 0);
      chk("rst_addr", mem_addr[0], 0);
      if_req[0]  = 1'b1;
      if_addr[0] = 32'h10;
      tick();
      chk("f_gnt", 32'(if_gnt[0]), 1);
      chk("f_en", 32'(mem_en[0]), 1);
      chk("f_addr", mem_addr[0], 32'h10);
      chk("f_we", 32'(mem_we[0]), 0);
      chk("f_be", 32'(mem_be[0]), 32'hF);
      if_req[0] = 1'b0;
      tick();
      chk("f_en_off", 32'(mem_en[0] | if_gnt[0]), 0);
      mem_rdata[0] = 32'h0050_0093;
      tick();
      mem_rdata[0] = 32'h2222_2222;
      chk("f_valid", 32'(if_valid[0]), 1);
      chk("f_rdata", if_rdata[0], 32'h0050_0093);
      chk("f_dvalid", 32'(d_valid[0]), 0);
      tick();
      chk("f_valid_pulse", 32'(if_valid[0]), 0);
      chk("f_hold", if_rdata[0], 32'h0050_0093);

      // tie out of reset, round-robin: data first
      rst_pulse(0);
      rst[0]     = 1'b1;
      if_req[0]  = 1'b1;
      if_addr[0] = 32'h20;
      d_req[0]   = 1'b1;
      d_we[0]    = 1'b0;
      d_addr[0]  = 32'h200;
      tick();
      chk("t_dgnt", 32'(d_gnt[0]), 1);
      chk("t_ignt", 32'(if_gnt[0]), 0);
      chk("t_daddr", mem_addr[0], 32'h200);
      d_req[0] = 1'b0;
      tick();
      mem_rdata[0] = 32'hCAFE_0001;
      tick();
      mem_rdata[0] = 32'h3333_3333;
      chk("t_dvalid", 32'(d_valid[0]), 1);
      chk("t_drdata", d_rdata[0], 32'hCAFE_0001);
      chk("t_ivalid0", 32'(if_valid[0]), 0);
      tick();
      chk("t_ignt4", 32'(if_gnt[0]), 1);
      chk("t_iaddr", mem_addr[0], 32'h20);
      if_req[0] = 1'b0;
      tick();
      mem_rdata[0] = 32'h0000_0013;
      tick();
      mem_rdata[0] = 32'h4444_4444;
      chk("t_ivalid6", 32'(if_valid[0]), 1);
      chk("t_irdata", if_rdata[0], 32'h13);
      chk("t_dvalid6", 32'(d_valid[0]), 0);
      tick();

      // store: byte enables pass, response register untouched
      d_req[0]   = 1'b1;
      d_we[0]    = 1'b1;
      d_addr[0]  = 32'h100;
      d_wdata[0] = 32'hDEAD_BEEF;
      d_be[0]    = 4'h3;
      tick();
      chk("s_gnt", 32'(d_gnt[0]), 1);
      chk("s_en", 32'(mem_en[0]), 1);
      chk("s_we", 32'(mem_we[0]), 1);
      chk("s_be", 32'(mem_be[0]), 32'h3);
      chk("s_wdata", mem_wdata[0], 32'hDEAD_BEEF);
      chk("s_addr", mem_addr[0], 32'h100);
      d_req[0] = 1'b0;
      d_we[0]  = 1'b0;
      tick();
      chk("s_en_off", 32'(mem_en[0]), 0);
      mem_rdata[0] = 32'h5555_5555;
      tick();
      chk("s_valid", 32'(d_valid[0]), 1);
      chk("s_rdata", d_rdata[0], 32'h13);
      tick();

      // both held, round-robin: strict alternation, fetch first
      if_req[0]  = 1'b1;
      if_addr[0] = 32'h40;
      d_req[0]   = 1'b1;
      d_addr[0]  = 32'h300;
      exp_d = 1'b0;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (if_gnt[0] || d_gnt[0]) begin
            chk("rr_both", 32'(if_gnt[0] & d_gnt[0]), 0);
            chk("rr_owner", 32'(d_gnt[0]), 32'(exp_d));
            exp_d = ~exp_d;
            n++;
         end
      end
      chk("rr_count", 32'(n), 14);
      if_req[0] = 1'b0;
      d_req[0]  = 1'b0;
      for (int k = 0; k < 6; k++)
         tick();

      // LAT=3 fetch stream with stepping address
      rst_pulse(1);
      rst[1]     = 1'b1;
      if_req[1]  = 1'b1;
      if_addr[1] = 32'h0;
      a = 32'h0;
      for (int c = 0; c <= 16; c++) begin
         if (c > 0)
            tick();
         mem_rdata[1] = 32'hA000_0000 + 32'(c);
         chk($sformatf("l3_gnt_c%0d", c), 32'(if_gnt[1]),
             32'(c == 1 || c == 6 || c == 11));
         chk($sformatf("l3_val_c%0d", c), 32'(if_valid[1]),
             32'(c == 5 || c == 10 || c == 15));
         if (if_valid[1])
            chk("l3_rdata", if_rdata[1], 32'hA000_0000 + 32'(c - 1));
         if (if_gnt[1]) begin
            chk("l3_addr", mem_addr[1], a);
            a = a + 32'd4;
            if_addr[1] = a;
            if (c == 11)
               if_req[1] = 1'b0;
         end
      end

      // both held, data priority: fetch starves
      if_req[1] = 1'b1;
      d_req[1]  = 1'b1;
      d_addr[1] = 32'h400;
      ni = 0;
      nd = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (if_gnt[1])
            ni++;
         if (d_gnt[1])
            nd++;
      end
      chk("dp_if_gnts", 32'(ni), 0);
      chk("dp_d_gnts", 32'(nd), 8);
      if_req[1] = 1'b0;
      d_req[1]  = 1'b0;
      for (int k = 0; k < 8; k++)
         tick();

      // LAT=4 reset in WAIT aborts the transaction
      rst_pulse(2);
      rst[2]       = 1'b1;
      if_req[2]    = 1'b1;
      if_addr[2]   = 32'h80;
      mem_rdata[2] = 32'h7777_7777;
      tick();
      chk("ab_gnt", 32'(if_gnt[2]), 1);
      if_req[2] = 1'b0;
      tick();
      tick();
      rst[2] = 1'b0;
      tick();
      rst[2] = 1'b1;
      chk("ab_en", 32'(mem_en[2] | mem_we[2]), 0);
      chk("ab_gv", 32'(if_gnt[2] | d_gnt[2] | if_valid[2] | d_valid[2]), 0);
      chk("ab_rdata", if_rdata[2], 0);
      chk("ab_addr", mem_addr[2], 0);
      chk("ab_be", 32'(mem_be[2]), 0);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (if_valid[2] || d_valid[2] || mem_en[2] || if_gnt[2] || d_gnt[2])
            bad++;
      end
      chk("ab_quiet", 32'(bad), 0);
      d_req[2]  = 1'b1;
      d_addr[2] = 32'h44;
      tick();
      chk("ab_idle_gnt", 32'(d_gnt[2]), 1);
      chk("ab_idle_addr", mem_addr[2], 32'h44);
      d_req[2] = 1'b0;
      for (int k = 0; k < 8; k++)
         tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
